// File: rtl/laser_search_ctrl_if.sv
// Request/response channel between the search sequencer and the shared
// coverage-count datapath.
interface laser_search_ctrl_if #(
  parameter int CW = 6
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cx;
  logic [3:0]    req_cy;
  logic [3:0]    fix_x;
  logic [3:0]    fix_y;
  logic          resp_valid;
  logic [CW-1:0] resp_cnt;

  modport master (
    output req_valid, req_cx, req_cy, fix_x, fix_y,
    input  req_ready, resp_valid, resp_cnt
  );

  modport slave (
    input  req_valid, req_cx, req_cy, fix_x, fix_y,
    output req_ready, resp_valid, resp_cnt
  );
endinterface

// File: rtl/laser_search_ctrl.sv
// Alternating coordinate-descent search over a 16x16 grid for two laser
// circle centers; one candidate is evaluated at a time by the shared datapath.
//
// state  | meaning
// IDLE   | waiting for start from the point loader
// ISSUE  | presenting candidate to datapath (req_valid high)
// WAIT   | request accepted, waiting for coverage count
// EVAL   | end of sweep: commit best position, decide continue/stop
// FINISH | publish final centers, DONE pulse
module laser_search_ctrl #(
  parameter int INIT_X     = 8,
  parameter int INIT_Y     = 8,
  parameter int CW         = 6,
  parameter int MAX_SWEEPS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  laser_search_ctrl_if.master bus,
  output logic                busy,
  output logic [3:0]          C1X,
  output logic [3:0]          C1Y,
  output logic [3:0]          C2X,
  output logic [3:0]          C2Y,
  output logic                DONE
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, FINISH} state_t;

  state_t        state, state_nxt;
  logic [3:0]    c1x, c1y, c2x, c2y;
  logic [3:0]    cand_x, cand_y;
  logic [3:0]    best_x, best_y;
  logic [CW-1:0] best_cnt, prev_total;
  logic [1:0]    no_imp, no_imp_nxt;
  logic [7:0]    sweep, sweep_nxt;
  logic          swept;
  logic          last_cand, improve, stop, active;

  // Even sweeps move C1, odd sweeps move C2.
  assign swept      = sweep[0];
  assign last_cand  = (cand_x == 4'hF) && (cand_y == 4'hF);
  assign improve    = best_cnt > prev_total;
  assign no_imp_nxt = improve ? 2'd0 : no_imp + 2'd1;
  assign sweep_nxt  = sweep + 8'd1;
  assign stop       = (no_imp_nxt == 2'd2) || (sweep_nxt == 8'(MAX_SWEEPS));
  assign active     = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (bus.req_ready) state_nxt = WAIT;
      WAIT:    if (bus.resp_valid) state_nxt = last_cand ? EVAL : ISSUE;
      EVAL:    state_nxt = stop ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c1x        <= 4'(INIT_X);
      c1y        <= 4'(INIT_Y);
      c2x        <= 4'(INIT_X);
      c2y        <= 4'(INIT_Y);
      cand_x     <= '0;
      cand_y     <= '0;
      best_x     <= 4'(INIT_X);
      best_y     <= 4'(INIT_Y);
      best_cnt   <= '0;
      prev_total <= '0;
      no_imp     <= '0;
      sweep      <= '0;
      C1X        <= '0;
      C1Y        <= '0;
      C2X        <= '0;
      C2Y        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c1x        <= 4'(INIT_X);
          c1y        <= 4'(INIT_Y);
          c2x        <= 4'(INIT_X);
          c2y        <= 4'(INIT_Y);
          cand_x     <= '0;
          cand_y     <= '0;
          best_x     <= 4'(INIT_X);
          best_y     <= 4'(INIT_Y);
          best_cnt   <= '0;
          prev_total <= '0;
          no_imp     <= '0;
          sweep      <= '0;
        end
        WAIT: if (bus.resp_valid) begin
          // Strict compare: on ties the earlier scan position wins.
          if (bus.resp_cnt > best_cnt) begin
            best_cnt <= bus.resp_cnt;
            best_x   <= cand_x;
            best_y   <= cand_y;
          end
          if (!last_cand) begin
            cand_x <= cand_x + 4'd1;
            if (cand_x == 4'hF) cand_y <= cand_y + 4'd1;
          end
        end
        EVAL: begin
          if (improve) begin
            if (swept) begin
              c2x <= best_x;
              c2y <= best_y;
            end else begin
              c1x <= best_x;
              c1y <= best_y;
            end
            prev_total <= best_cnt;
          end
          no_imp <= no_imp_nxt;
          sweep  <= sweep_nxt;
          if (!stop) begin
            cand_x   <= '0;
            cand_y   <= '0;
            best_cnt <= '0;
          end
        end
        FINISH: begin
          C1X <= c1x;
          C1Y <= c1y;
          C2X <= c2x;
          C2Y <= c2y;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_valid = (state == ISSUE);
  assign bus.req_cx    = active ? cand_x : 4'd0;
  assign bus.req_cy    = active ? cand_y : 4'd0;
  assign bus.fix_x     = active ? (swept ? c1x : c2x) : 4'd0;
  assign bus.fix_y     = active ? (swept ? c1y : c2y) : 4'd0;
  assign busy          = active;
  assign DONE          = (state == FINISH);

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Directed + randomized bench for laser_search_ctrl with a stub coverage
// datapath and a loop-level model of the search result.
module tb_laser_search_ctrl;
  localparam int CW         = 6;
  localparam int MAX_SWEEPS = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       busy, DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;

  laser_search_ctrl_if #(.CW(CW)) bus ();

  laser_search_ctrl #(
    .INIT_X(8), .INIT_Y(8), .CW(CW), .MAX_SWEEPS(MAX_SWEEPS)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .bus(bus), .busy(busy),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int         mode;
  bit         stall_en, dly_en;
  bit         ready_given, pending, armed;
  int         wait_left, stall_left, nresp, done_cnt, pend_val;
  logic [15:0] snap;
  int         rtab[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coverage count returned by the stub for one candidate.
  function automatic int resp_of(input int m, input int x, input int y,
                                 input int fx, input int fy, input int idx);
    case (m)
      0:       return (x == 3 && y == 4) ? 40 : 10;
      1:       return 7;
      2:       return idx / 256 + 1;
      default: return rtab[((y * 16 + x) ^ (fy * 16 + fx)) & 255];
    endcase
  endfunction

  // Search outcome computed directly from the sweep rules.
  function automatic void model(input int m, output int ox1, output int oy1,
                                output int ox2, output int oy2, output int nr);
    int cx[2], cy[2];
    int prev, noimp, best, bx, by, r, sw;
    cx[0] = 8; cy[0] = 8; cx[1] = 8; cy[1] = 8;
    prev = 0; noimp = 0; nr = 0;
    for (int s = 0; s < MAX_SWEEPS; s++) begin
      sw = s % 2;
      best = 0; bx = cx[sw]; by = cy[sw];
      for (int k = 0; k < 256; k++) begin
        r = resp_of(m, k % 16, k / 16, cx[1-sw], cy[1-sw], nr);
        nr++;
        if (r > best) begin best = r; bx = k % 16; by = k / 16; end
      end
      if (best > prev) begin
        cx[sw] = bx; cy[sw] = by; prev = best; noimp = 0;
      end else noimp++;
      if (noimp == 2) break;
    end
    ox1 = cx[0]; oy1 = cy[0]; ox2 = cx[1]; oy2 = cy[1];
  endfunction

  // One clock of the stub datapath, evaluated at the falling edge.
  task automatic tick();
    @(negedge CLK);
    if (DONE) done_cnt++;
    bus.resp_valid = 1'b0;
    if (RST) begin
      ready_given = 0; pending = 0; armed = 0;
      bus.req_ready = 1'b0;
      return;
    end
    if (ready_given) begin
      ready_given   = 0;
      bus.req_ready = 1'b0;
      pending       = 1;
      wait_left     = dly_en ? int'($urandom_range(1, 6)) : 1;
      pend_val      = resp_of(mode, int'(snap[15:12]), int'(snap[11:8]),
                              int'(snap[7:4]), int'(snap[3:0]), nresp);
    end
    if (pending) begin
      chk("one_outstanding", {31'd0, bus.req_valid}, 32'd0);
      wait_left--;
      if (wait_left == 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_cnt   = CW'(pend_val);
        pending        = 0;
        nresp++;
      end
    end else if (bus.req_valid) begin
      if (!armed) begin
        armed      = 1;
        stall_left = stall_en ? int'($urandom_range(0, 4)) : 0;
        snap       = {bus.req_cx, bus.req_cy, bus.fix_x, bus.fix_y};
      end else begin
        chk("req_stable", {16'd0, bus.req_cx, bus.req_cy, bus.fix_x, bus.fix_y}, {16'd0, snap});
      end
      if (stall_left == 0) begin
        bus.req_ready = 1'b1;
        ready_given   = 1;
        armed         = 0;
      end else stall_left--;
    end
  endtask

  task automatic run_search(input int m, input bit stl, input bit dly,
                            input bit mid_start, input string tag);
    int e1x, e1y, e2x, e2y, enr, cyc;
    bit mid_done;
    model(m, e1x, e1y, e2x, e2y, enr);
    mode = m; stall_en = stl; dly_en = dly;
    nresp = 0; done_cnt = 0; mid_done = 0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (cyc = 0; cyc < 40000 && done_cnt == 0; cyc++) begin
      tick();
      if (mid_start && !mid_done && nresp == 100) begin
        start = 1'b1; mid_done = 1;
      end else start = 1'b0;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    // start coincident with DONE must be ignored
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_nresp"}, nresp, enr);
    chk({tag, "_c1x"}, {28'd0, C1X}, e1x);
    chk({tag, "_c1y"}, {28'd0, C1Y}, e1y);
    chk({tag, "_c2x"}, {28'd0, C2X}, e2x);
    chk({tag, "_c2y"}, {28'd0, C2Y}, e2y);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_valid"}, {31'd0, bus.req_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.req_valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_cout"}, {16'd0, C1X, C1Y, C2X, C2Y}, 32'd0);
    chk({tag, "_req"}, {16'd0, bus.req_cx, bus.req_cy, bus.fix_x, bus.fix_y}, 32'd0);
  endtask

  initial begin
    int any_hi, cyc;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_cnt = '0;
    ready_given = 0; pending = 0; armed = 0; nresp = 0; done_cnt = 0;
    mode = 0; stall_en = 0; dly_en = 0;
    foreach (rtab[i]) rtab[i] = 0;

    // Reset and quiet idle
    tick(); tick();
    RST = 1'b0;
    any_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || bus.req_valid || DONE) any_hi++;
    end
    chk("idle_no_activity", any_hi, 0);
    chk_reset_outputs("reset");

    run_search(0, 0, 0, 0, "peak");
    run_search(1, 0, 0, 0, "const");
    run_search(2, 0, 0, 0, "maxsweep");
    run_search(0, 1, 1, 0, "stall");

    foreach (rtab[i]) rtab[i] = int'($urandom_range(0, 40));
    run_search(3, 0, 0, 0, "rand0");
    foreach (rtab[i]) rtab[i] = int'($urandom_range(0, 40));
    run_search(3, 1, 1, 0, "rand1");

    // Reset during sweep 1 while a response is outstanding
    mode = 0; stall_en = 0; dly_en = 0; nresp = 0; done_cnt = 0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (cyc = 0; cyc < 2000 && !(nresp >= 300 && ready_given); cyc++) tick();
    chk("abort_reached_sweep1", {31'd0, ready_given}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    bus.resp_cnt   = CW'(40);
    bus.resp_valid = 1'b1;
    any_hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || bus.req_valid || DONE) any_hi++;
    end
    chk("abort_quiet", any_hi, 0);
    chk_reset_outputs("abort");

    run_search(0, 0, 0, 1, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/laser_search_ctrl.md
Name: laser_search_ctrl

Overview:
- Sequencing controller for the two-circle laser coverage search.
- Starts once the point loader has captured all 40 (X,Y) points.
- Runs an alternating coordinate-descent search:
  - Even sweeps fix C2 and evaluate all 256 grid positions for C1.
  - Odd sweeps fix C1 and evaluate all 256 positions for C2.
- Each candidate goes to the shared coverage-count datapath over a valid/ready request and response handshake.
- Keeps the best result and reports final centers C1X/C1Y/C2X/C2Y with a DONE pulse.

Parameters:
- INIT_X, 8: initial X of both centers.
- INIT_Y, 8: initial Y of both centers.
- CW, 6: width of the coverage count (max 40 points).
- MAX_SWEEPS, 8: hard limit on the number of sweeps per search.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- start  in  1  one-cycle pulse from the loader: point memory full, begin search
- req_valid  out  1  candidate request valid
- req_ready  in  1  datapath accepts request
- req_cx  out  4  candidate center X
- req_cy  out  4  candidate center Y
- fix_x  out  4  X of the other, fixed center
- fix_y  out  4  Y of the other, fixed center
- resp_valid  in  1  one-cycle pulse, coverage result ready
- resp_cnt  in  CW  number of points covered by the union of the candidate and fixed circles
- busy  out  1  search in progress
- C1X  out  4  final center 1 X
- C1Y  out  4  final center 1 Y
- C2X  out  4  final center 2 X
- C2Y  out  4  final center 2 Y
- DONE  out  1  one-cycle pulse, final centers valid

Behaviour:
- Reset (RST asynchronous, active-high; clock CLK; all flops async-reset):
  - State IDLE; req_valid=0, busy=0, DONE=0.
  - C1X/C1Y/C2X/C2Y=0; req_cx/req_cy/fix_x/fix_y=0.
  - Internal centers = (INIT_X, INIT_Y); sweep counter=0; prev_total=0; no-improve counter=0.
- States: IDLE, ISSUE, WAIT, EVAL, FINISH.
- IDLE:
  - On start: load both internal centers with (INIT_X, INIT_Y), prev_total=0, sweep=0, no_imp=0, cand=(0,0), best_cnt=0, best_pos=current center of the swept circle.
  - Go to ISSUE; busy=1 from the next cycle.
- ISSUE:
  - req_valid=1 with req_cx/req_cy=cand; fix_x/fix_y = the non-swept center (C2 on even sweeps, C1 on odd sweeps).
  - Outputs stay stable while req_valid=1 and req_ready=0.
  - On req_valid&&req_ready go to WAIT; req_valid=0 next cycle.
  - Only one request is outstanding at a time.
- WAIT:
  - Hold until resp_valid.
  - If resp_cnt > best_cnt (strict), then best_cnt=resp_cnt and best_pos=cand. Ties keep the earlier candidate.
  - Scan order: Y outer, X inner, 0..15, i.e. (0,0),(1,0)..(15,0),(0,1)..(15,15).
  - If cand=(15,15), go to EVAL. Otherwise advance cand and go to ISSUE.
  - resp_valid outside WAIT is ignored.
- EVAL (1 cycle):
  - Improvement if best_cnt > prev_total. On improvement: swept center = best_pos, prev_total=best_cnt, no_imp=0.
  - Otherwise the centers are unchanged and no_imp increments.
  - sweep increments.
  - If no_imp reaches 2 or sweep reaches MAX_SWEEPS, go to FINISH.
  - Otherwise reset cand=(0,0) and best_cnt=0, toggle the swept circle, and go to ISSUE.
- FINISH (1 cycle):
  - C1X/C1Y/C2X/C2Y = internal centers; DONE=1 for exactly this one cycle; busy=0 next cycle; return to IDLE.
  - C outputs hold until the next FINISH or reset.
- start while busy is ignored.
- start in the same cycle as the DONE pulse is also ignored; it is accepted from the following IDLE cycle.
- Reset mid-search aborts immediately: no further requests, and a late resp_valid in IDLE is ignored.
- Minimum cost is 2 cycles per candidate (ISSUE+WAIT, with ready and response each 1 cycle). A full sweep is therefore at least 512 cycles plus 1 EVAL.

Test Plan:
1. Reset, no start for 20 cycles → busy=0, req_valid=0, DONE=0, all C outputs 0.
2. Stub datapath: resp_cnt=40 when cand=(3,4), else 10; req_ready=1, 1-cycle response; pulse start.
   - Sweep0 improves (40>0); sweeps 1 and 2 do not.
   - DONE after exactly 768 responses, with C1=(3,4), C2=(8,8).
3. Stub returns constant 7 → sweep0 picks the first candidate, so C1=(0,0); C2 stays (8,8); 768 responses, DONE once.
4. Stub returns (sweep index+1) for every candidate, so every sweep improves → terminates on MAX_SWEEPS=8 after 2048 responses.
   - Final C1=(0,0) (last even sweep), C2=(0,0).
5. Repeat scenario 2 with random req_ready stalls (0–4 cycles) and response delays (1–6 cycles) → identical final centers and response count.
   - req_cx/req_cy/fix_x/fix_y stable throughout every stalled request.
   - Never more than one outstanding request.
6. Assert RST during sweep1 while in WAIT, then inject resp_valid → no state change, all outputs at reset values.
   - A new start then reruns scenario 2 with identical results.
   - A start pulsed mid-search in scenario 2 has no effect.
